// File: rtl/spi_slave_pkg.sv
// Shared constants for the 16-bit SPI responder: default frame geometry and FSM encodings.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package spi_slave_pkg;

    // Default frame length in bits (MSB first) and synchronizer depth.
    localparam int SPI_DATA_WIDTH  = 16;
    localparam int SPI_SYNC_STAGES = 2;

    // Responder FSM encodings, kept as plain vectors so older tools and
    // logic-analyser decoders see the same values.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    // The bit counter has one bit more than needed to address a frame bit,
    // so it can hold DATA_WIDTH itself without wrapping.
    function automatic int spi_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus the application-side word/handshake for the SPI responder.
// Latency: n/a (wiring only).
// Backpressure: none; the application must sample data_rx on the transfer_done pulse.
//
// Signals:
//   sclk, cs, mosi, miso       - board pins (mode 0, cs active-low)
//   data_to_tx                 - word returned to the master, captured on cs fall
//   data_rx                    - last complete received word
//   transfer_done / frame_error - one-cycle pulses; transfer_busy - frame active
interface spi_slave_if import spi_slave_pkg::*; #(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) ();

    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] data_to_tx;
    logic [DATA_WIDTH-1:0] data_rx;
    logic                  transfer_done;
    logic                  transfer_busy;
    logic                  frame_error;

    modport slave (
        input  sclk, cs, mosi, data_to_tx,
        output miso, data_rx, transfer_done, transfer_busy, frame_error
    );

    modport master (
        output sclk, cs, mosi, data_to_tx,
        input  miso, data_rx, transfer_done, transfer_busy, frame_error
    );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
// Latency: a pin edge shows up as a one-cycle pulse STAGES clocks later.
// Backpressure: none; pulses are emitted unconditionally.
//
// Ports:
//   i_clk, i_reset  - system clock, synchronous active-high reset
//   i_pin           - asynchronous input
//   o_rise, o_fall  - one-cycle edge pulses in the i_clk domain
module spi_slave_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;
    logic              r_rise;
    logic              r_fall;

    logic w_prev;
    logic w_next;
    logic w_armed;

    // Edge detection compares the last two synchronizer flops, so the pulse
    // register lands in the same cycle the last flop takes the new level.
    assign w_prev  = r_sync[STAGES-1];
    assign w_next  = r_sync[STAGES-2];

    // Pulses are held off until the chain has been flushed with real pin
    // samples after reset; otherwise the step from RST_VAL to a pin that was
    // already at the other level (e.g. cs held low across reset) would be
    // reported as an edge.
    assign w_armed = r_fill[STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_fill <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_fill <= {r_fill[STAGES-2:0], 1'b1};
            r_rise <= w_armed &  w_next & ~w_prev;
            r_fall <= w_armed & ~w_next &  w_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: shifts in a DATA_WIDTH-bit frame on MOSI while returning a preloaded word on MISO.
// Latency: SYNC_STAGES+1 clocks from any pin edge to its registered effect (3 at default).
// Backpressure: none; data_rx is valid on the transfer_done pulse and held until the next complete frame.
//
// Ports:
//   i_clk    - system clock (24 MHz); all logic, including SPI sampling, runs on it
//   i_reset  - synchronous, active-high
//   io_bus   - spi_slave_if.slave: pins sclk/cs/mosi/miso and data_to_tx/data_rx,
//              transfer_done, transfer_busy, frame_error
module spi_slave import spi_slave_pkg::*; #(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic           i_clk,
    input  logic           i_reset,
    spi_slave_if.slave     io_bus
);

    localparam int                CNT_W    = spi_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;

    spi_slave_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_sclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pin   (io_bus.sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_slave_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_cs (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pin   (io_bus.cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // MOSI only needs its level. Taking it from the last flop of an
    // equally deep chain lines it up with the sclk rise pulse, which is
    // derived from the second-to-last sclk flop one cycle earlier.
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_data_rx;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_data_rx  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        // MISO is the MSB of the tx register, so loading it
                        // presents the first bit before the first sclk rise.
                        r_tx_shift <= io_bus.data_to_tx;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // A cs release takes priority over any sclk edge seen
                    // in the same cycle.
                    if (w_cs_rise) begin
                        r_err      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_shift <= '0;
                        r_state    <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_data_rx  <= {r_rx_shift, w_mosi};
                            r_done     <= 1'b1;
                            r_tx_shift <= '0;
                            r_state    <= ST_WAIT_CS;
                        end
                    end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        // Falls only follow a rise in mode 0; the count guard
                        // keeps a stray fall from skipping the MSB.
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end

                ST_WAIT_CS: begin
                    // Extra clocks from the master are ignored and MISO is
                    // held low until the frame is closed.
                    r_tx_shift <= '0;
                    if (w_cs_rise) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx_shift <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.miso          = r_tx_shift[DATA_WIDTH-1];
    assign io_bus.data_rx       = r_data_rx;
    assign io_bus.transfer_done = r_done;
    assign io_bus.transfer_busy = r_busy;
    assign io_bus.frame_error   = r_err;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI mode-0 master on the pins and checks returned/received words.
// Latency: checks the 3-cycle pin-to-done latency and single-cycle pulse widths.
// Backpressure: n/a.
module tb_spi_slave;

    localparam int HALF = 6;   // sclk half period in clk cycles

    logic clk;
    logic reset;
    int   cyc;

    int n_tests;
    int n_fail;

    int done_cnt;
    int err_cnt;
    int done_wide;
    int done_cyc;
    int last_rise_cyc;
    logic prev_done;

    int done_snap;
    int err_snap;
    logic [31:0] got;
    logic [31:0] got2;

    spi_slave_if #(.DATA_WIDTH(16)) bus ();

    spi_slave #(
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.transfer_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (prev_done === 1'b1) done_wide = done_wide + 1;
        end
        prev_done = bus.transfer_done;
        if (bus.frame_error === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Master side of a mode-0 transfer; bits are MSB-aligned in a 32-bit word.
    // Leaves cs low so callers can extend, abort or close the frame.
    task automatic spi_xfer(input logic [31:0] bits, input int nbits, output logic [31:0] rd);
        rd = '0;
        @(negedge clk);
        bus.cs   = 1'b0;
        bus.mosi = bits[31];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.sclk      = 1'b1;
            rd[31-i]      = bus.miso;
            last_rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
            if (i + 1 < nbits) bus.mosi = bits[31-(i+1)];
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic cs_release(input int gap);
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0;
        done_cnt = 0; err_cnt = 0; done_wide = 0; done_cyc = 0; last_rise_cyc = 0;
        prev_done = 1'b0;
        reset = 1'b1;
        bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.data_to_tx = 16'h0000;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_data_rx", {16'h0, bus.data_rx}, 32'h0);
        check("rst_done",    {31'h0, bus.transfer_done}, 32'h0);
        check("rst_busy",    {31'h0, bus.transfer_busy}, 32'h0);
        check("rst_err",     {31'h0, bus.frame_error}, 32'h0);
        check("rst_miso",    {31'h0, bus.miso}, 32'h0);

        // Single frame
        done_snap = done_cnt; err_snap = err_cnt;
        bus.data_to_tx = 16'h3C5A;
        spi_xfer(32'hA5C3_0000, 16, got);
        check("t1_busy_in_frame", {31'h0, bus.transfer_busy}, 32'h1);
        check("t1_done_latency",  done_cyc - last_rise_cyc, 32'd3);
        cs_release(HALF);
        check("t1_rx",       {16'h0, bus.data_rx}, 32'h0000_A5C3);
        check("t1_tx",       got, 32'h3C5A_0000);
        check("t1_done_cnt", done_cnt - done_snap, 32'd1);
        check("t1_err_cnt",  err_cnt - err_snap, 32'd0);
        check("t1_busy_end", {31'h0, bus.transfer_busy}, 32'h0);

        // Abort after 7 bits
        done_snap = done_cnt; err_snap = err_cnt;
        bus.data_to_tx = 16'hFFFF;
        spi_xfer(32'h1234_0000, 7, got);
        cs_release(HALF);
        check("ab_err_cnt",  err_cnt - err_snap, 32'd1);
        check("ab_done_cnt", done_cnt - done_snap, 32'd0);
        check("ab_rx_kept",  {16'h0, bus.data_rx}, 32'h0000_A5C3);
        check("ab_busy",     {31'h0, bus.transfer_busy}, 32'h0);
        check("ab_miso",     {31'h0, bus.miso}, 32'h0);

        // Full frame after the abort
        done_snap = done_cnt;
        bus.data_to_tx = 16'h0F0F;
        spi_xfer(32'hBEEF_0000, 16, got);
        cs_release(HALF);
        check("ab2_rx",       {16'h0, bus.data_rx}, 32'h0000_BEEF);
        check("ab2_tx",       got, 32'h0F0F_0000);
        check("ab2_done_cnt", done_cnt - done_snap, 32'd1);

        // Back-to-back frames with a 3-cycle cs gap
        done_snap = done_cnt;
        bus.data_to_tx = 16'h8000;
        spi_xfer(32'h0001_0000, 16, got);
        bus.data_to_tx = 16'h7FFF;
        cs_release(2);
        check("b2b_rx1", {16'h0, bus.data_rx}, 32'h0000_0001);
        check("b2b_tx1", got, 32'h8000_0000);
        spi_xfer(32'hFFFF_0000, 16, got);
        cs_release(HALF);
        check("b2b_rx2",      {16'h0, bus.data_rx}, 32'h0000_FFFF);
        check("b2b_tx2",      got, 32'h7FFF_0000);
        check("b2b_done_cnt", done_cnt - done_snap, 32'd2);

        // Reset mid-frame with cs held low
        done_snap = done_cnt; err_snap = err_cnt;
        bus.data_to_tx = 16'hFFFF;
        spi_xfer(32'hAB00_0000, 8, got);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rmf_miso_after_rst", {31'h0, bus.miso}, 32'h0);
        check("rmf_rx_after_rst",   {16'h0, bus.data_rx}, 32'h0);
        spi_xfer(32'hCD00_0000, 8, got);
        check("rmf_miso_bits", got, 32'h0);
        check("rmf_busy",      {31'h0, bus.transfer_busy}, 32'h0);
        cs_release(HALF);
        check("rmf_done_cnt",  done_cnt - done_snap, 32'd0);
        check("rmf_err_cnt",   err_cnt - err_snap, 32'd0);
        check("rmf_rx",        {16'h0, bus.data_rx}, 32'h0);
        bus.data_to_tx = 16'hA0A0;
        spi_xfer(32'h5555_0000, 16, got);
        cs_release(HALF);
        check("rmf_rx2", {16'h0, bus.data_rx}, 32'h0000_5555);
        check("rmf_tx2", got, 32'hA0A0_0000);

        // 20 sclk cycles: 0xC0DE followed by 4 junk bits
        done_snap = done_cnt;
        bus.data_to_tx = 16'h9669;
        spi_xfer(32'hC0DE_A000, 20, got);
        check("xc_miso_tail", {16'h0, got[15:0]}, 32'h0);
        check("xc_busy",      {31'h0, bus.transfer_busy}, 32'h1);
        cs_release(HALF);
        check("xc_rx",        {16'h0, bus.data_rx}, 32'h0000_C0DE);
        check("xc_tx",        {16'h0, got[31:16]}, 32'h0000_9669);
        check("xc_done_cnt",  done_cnt - done_snap, 32'd1);

        // data_to_tx changed mid-frame
        bus.data_to_tx = 16'h1111;
        spi_xfer(32'h3300_0000, 8, got);
        bus.data_to_tx = 16'h2222;
        spi_xfer(32'h0000_0000, 8, got2);
        cs_release(HALF);
        check("chg_tx", {16'h0, got[31:24], got2[31:24]}, 32'h0000_1111);
        check("chg_rx", {16'h0, bus.data_rx}, 32'h0000_3300);
        spi_xfer(32'h4444_0000, 16, got);
        cs_release(HALF);
        check("chg_tx_next", got, 32'h2222_0000);
        check("chg_rx_next", {16'h0, bus.data_rx}, 32'h0000_4444);

        check("done_width", done_wide, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Peripheral (responder) end of the team's 16-bit SPI link: receives frames from the SPI master on another board and shifts a preloaded word back on MISO in the same frame. Runs entirely on the system clock (24 MHz from SB_HFOSC /2) and oversamples SCLK/CS/MOSI through synchronizers; no logic is clocked by SCLK. Sits between the board pins and the application FSM, mirroring the master's start/done/busy handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, frame length in bits (MSB first)
- SYNC_STAGES, 2, synchronizer flops on SCLK, CS, MOSI (≥2)

Ports:
- clk  in  1  system clock, 24 MHz
- reset  in  1  synchronous, active-high
- data_to_tx  in  DATA_WIDTH  word returned to master; captured on CS falling edge
- data_rx  out  DATA_WIDTH  last complete received word; reset 0
- transfer_done  out  1  one-cycle pulse, data_rx just updated; reset 0
- transfer_busy  out  1  high while a frame is active; reset 0
- frame_error  out  1  one-cycle pulse, CS released before DATA_WIDTH bits; reset 0
- sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- cs  in  1  chip select, active-low
- mosi  in  1  master-out data
- miso  out  1  slave-out data; reset 0, 0 whenever no frame active

## Operation
- Mode 0: MOSI sampled on SCLK rising edge; MISO updated on SCLK falling edge; first bit (MSB) on MISO before first rising edge.
- Synchronizer reset values: sclk 0, cs 1, mosi 0. Frame start requires a detected CS falling edge, not CS level.
- States: IDLE, SHIFT, WAIT_CS.
- IDLE: on CS fall → load tx shift reg from data_to_tx, miso ← data_to_tx[MSB], bit_cnt ← 0, transfer_busy ← 1, go SHIFT.
- SHIFT, SCLK rise: rx shift reg ← {rx[W-2:0], mosi}, bit_cnt+1. On the DATA_WIDTH-th rise: data_rx ← assembled word, transfer_done pulse, go WAIT_CS.
- SHIFT, SCLK fall: tx reg shifts left, miso ← next bit. Fall after last rise ignored.
- SHIFT, CS rise: frame_error pulse, data_rx unchanged, transfer_busy ← 0, miso ← 0, go IDLE.
- WAIT_CS: all SCLK edges ignored, miso ← 0; on CS rise → transfer_busy ← 0, IDLE.
- CS rise and SCLK edge detected same cycle: CS rise wins.
- data_to_tx changes during a frame have no effect until next CS fall.
- bit_cnt width $clog2(DATA_WIDTH)+1; no wrap within a frame.
- Reset mid-frame: all outputs to reset values, state IDLE; remaining frame ignored since CS stays low (no new falling edge).

## Timing
- Pin-to-action latency: SYNC_STAGES+1 clk cycles (3 at default) from pin edge to registered effect.
- transfer_done rises 3 cycles after the last SCLK rising edge at the pin; width exactly 1 cycle.
- MISO valid 3 cycles after SCLK fall / CS fall at pin.
- Master constraints: SCLK high and low time ≥ 5 clk cycles (2.4 MHz at 24 MHz satisfies: 5 cycles/half); CS fall to first SCLK rise ≥ 5 clk cycles; CS high between frames ≥ 3 clk cycles.
- Back-to-back frames supported: new CS fall in IDLE starts next frame same as first.

## Structure
- Shared header SPI.vh: add SPI_DATA_WIDTH default and slave state encodings (IDLE, SHIFT, WAIT_CS) next to the existing rate constants.
- Sub-module spi_sync_edge: SYNC_STAGES-flop synchronizer with registered rise/fall pulses and configurable reset value; instantiated for sclk and cs; mosi uses synchronizer only (matched depth).

## Test plan
- Single frame: data_to_tx=0x3C5A, master sends 0xA5C3 at 2.4 MHz → data_rx=0xA5C3, master reads 0x3C5A, one transfer_done pulse, busy high only during CS low.
- Back-to-back: frames 0x0001 then 0xFFFF, tx 0x8000 then 0x7FFF, 3-cycle CS gap → both received/returned correctly, two done pulses.
- Abort: CS released after 7 bits of 0x1234 → frame_error pulse, data_rx keeps prior 0xA5C3, no done; next full frame 0xBEEF received.
- Reset mid-frame: reset after 8 bits with CS held low, remaining 8 clocks → no done, data_rx=0, miso=0; after CS cycle, frame 0x5555 received.
- Extra clocks: 20 SCLK cycles sending 0xC0DE then 4 junk bits → data_rx=0xC0DE, single done pulse, miso 0 after bit 16.
- data_to_tx changed from 0x1111 to 0x2222 mid-frame → master reads 0x1111; next frame returns 0x2222.
